// File: rtl/sr_defs.sv
// Shared definitions for the PISO serializer and its SIPO partner.
package sr_defs;

  // Default word width, shared with the downstream 4-bit SIPO
  localparam int SR_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a given word width (never narrower than 1 bit)
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH bit counter with clear, enable and terminal-count flag.
// Also usable on the SIPO side for word-complete detection.
module bit_counter
  import sr_defs::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [cnt_w(WIDTH)-1:0]   cnt,
  output logic                      tc
);

  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  assign tc = (cnt == LAST);

  // Count enabled cycles, wrap after the last bit; clear wins over enable
  always_ff @(posedge clk) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding the SIPO serial input.
// Words enter over valid/ready; bits leave one per clock with frame qualifiers.
// All outputs except in_ready are registered from next-state values, so the
// first bit appears the cycle after the accept edge.
module piso_serializer
  import sr_defs::*;
#(
  parameter int   WIDTH      = SR_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             accept;
  logic             so_nxt;
  logic             fe_nxt;

  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == ST_SHIFT),
    .cnt (cnt),
    .tc  (tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake; ready on the last bit allows gapless words
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    if (rst) in_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && tc);
    accept = in_valid && in_ready;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tc && !accept) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next shift-register contents and next registered output values
  always_comb begin
    sh_nxt = sh;
    if (accept)                 sh_nxt = in_data;
    else if (state == ST_SHIFT) sh_nxt = MSB_FIRST ? (sh << 1) : (sh >> 1);
    so_nxt = IDLE_LEVEL;
    if (state_nxt == ST_SHIFT) so_nxt = MSB_FIRST ? sh_nxt[WIDTH-1] : sh_nxt[0];
    // Next bit is the last one when the current bit is second-to-last and
    // no new word is loading (a load always restarts at bit 0)
    fe_nxt = (state == ST_SHIFT) && !tc && (cnt == CNT_W'(WIDTH - 2));
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh           <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sh           <= sh_nxt;
      serial_out   <= so_nxt;
      serial_valid <= (state_nxt == ST_SHIFT);
      frame_start  <= accept;
      frame_end    <= fe_nxt;
      busy         <= (state_nxt == ST_SHIFT);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three configurations
// (4-bit MSB-first, 4-bit LSB-first, 8-bit MSB-first idling high).
module tb_piso_serializer;

  typedef struct packed {
    logic       b;
    logic       fs;
    logic       fe;
    logic [7:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data_a  [3];
  logic       in_valid_a [3];
  logic       in_ready_a [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int   W   = (g == 2) ? 8 : 4;
    localparam bit   MSB = (g == 1) ? 1'b0 : 1'b1;
    localparam logic IDL = (g == 2) ? 1'b1 : 1'b0;
    localparam logic [7:0] WMASK = (W == 8) ? 8'hFF : 8'h0F;

    logic       so, sv, fs, fe, bz, rdy;
    exp_t       q[$];
    exp_t       cur;
    logic       cur_v;
    logic       m_rdy = 1'b0;
    logic [7:0] acc = 8'h00;
    int         idx = 0;

    assign in_ready_a[g] = rdy;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(MSB), .IDLE_LEVEL(IDL)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data_a[g][W-1:0]),
      .in_valid     (in_valid_a[g]),
      .in_ready     (rdy),
      .serial_out   (so),
      .serial_valid (sv),
      .frame_start  (fs),
      .frame_end    (fe),
      .busy         (bz)
    );

    // Reference model: on a handshake the word becomes W expected bits
    always @(posedge clk) begin
      if (!rst) q.delete();
      else if (in_valid_a[g] && m_rdy) begin
        for (int i = 0; i < W; i++)
          q.push_back('{b:    MSB ? in_data_a[g][W-1-i] : in_data_a[g][i],
                        fs:   (i == 0),
                        fe:   (i == W - 1),
                        word: in_data_a[g] & WMASK});
      end
    end

    // Monitor: one expected bit (or idle) per cycle, plus reassembled word
    always begin
      @(negedge clk); #1;
      cur_v = (q.size() > 0);
      if (cur_v) cur = q.pop_front();
      else       cur = '{b: IDL, fs: 1'b0, fe: 1'b0, word: 8'h00};
      m_rdy = rst && (!cur_v || cur.fe);
      chk("serial_valid", g, 8'(sv),  8'(cur_v));
      chk("serial_out",   g, 8'(so),  8'(cur.b));
      chk("frame_start",  g, 8'(fs),  8'(cur.fs));
      chk("frame_end",    g, 8'(fe),  8'(cur.fe));
      chk("busy",         g, 8'(bz),  8'(cur_v));
      chk("in_ready",     g, 8'(rdy), 8'(m_rdy));
      if (cur_v) begin
        if (cur.fs) begin acc = 8'h00; idx = 0; end
        if (idx < W) acc[MSB ? (W - 1 - idx) : idx] = so;
        idx++;
        if (cur.fe) chk("sipo_word", g, acc, cur.word);
      end
    end
  end

  // Present a word and hold it until the handshake edge; returns at the
  // negedge after acceptance with in_valid still high
  task automatic send(input int d, input logic [7:0] w);
    int n = 0;
    in_valid_a[d] = 1'b1;
    in_data_a[d]  = w;
    forever begin
      #2;
      if (in_ready_a[d]) break;
      @(negedge clk);
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL send_timeout dut%0d t=%0t got=no_ready expected=ready", d, $time);
        in_valid_a[d] = 1'b0;
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d, input int cycles);
    in_valid_a[d] = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d] = 1'b0;
      in_data_a[d]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single word
    send(0, 8'b1011); idle(0, 6);
    // Back-to-back words, second held during the first
    send(0, 8'b1011); send(0, 8'b0110); idle(0, 6);
    send(0, 8'b1001); send(0, 8'b1111); idle(0, 6);
    // Reset in the middle of a word, then a clean word
    send(0, 8'b1101); idle(0, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(0, 8'b0011); idle(0, 6);
    // LSB-first and 8-bit configurations
    send(1, 8'b1011); idle(1, 6);
    send(2, 8'hA5);   idle(2, 10);

    // Random words with random gaps or back-to-back
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 20; k++) begin
        send(d, 8'($urandom));
        if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(0, 3));
      end
      idle(d, 12);
    end

    repeat (4) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
